lcd_bus_if: RTL and testbench
=============================

# lcd_bus_if

HD44780-class 8-bit parallel bus engine sitting directly under the LCD text/command sequencer in `LCD_top`. It runs the mandatory power-up initialisation sequence on its own. After that it accepts one byte (command or character) at a time over a valid/ready handshake. For each byte it produces correctly timed `RS`/`RW`/`LCD`/`en` waveforms and enforces the controller execution delay before accepting the next byte. No busy-flag readback: `RW` is write-only, held low.

## Interface
Parameters (cycle counts at the 100 MHz system clock):
- `T_POWERUP`, 4_000_000: wait after reset before the first init write (40 ms).
- `T_SETUP`, 4: `RS`/`LCD` valid before `en` rises.
- `T_PULSE`, 50: `en` high width.
- `T_HOLD`, 2: `RS`/`LCD` held after `en` falls.
- `T_EXEC`, 4000: normal instruction/data execution wait (40 µs).
- `T_EXEC_LONG`, 164_000: clear/home execution wait (1.64 ms).

Ports:
- `clk` in 1: system clock.
- `rstBt` in 1: reset. **Synchronous, active-high.**
- `in_valid` in 1: upstream byte available.
- `in_ready` out 1: engine can accept a byte.
- `in_rs` in 1: 0 = command, 1 = character data.
- `in_data` in 8: byte to write.
- `init_done` out 1: init sequence complete; stays high until reset.
- `LCD` out 8: LCD data bus.
- `RS` out 1: register select.
- `RW` out 1: constant 0.
- `en` out 1: LCD enable strobe.
- `dbg_state` out 4: current state encoding, for `LEDs`.

## Operation
- States: POWERUP, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE.
- Reset values: `en`=0, `RS`=0, `RW`=0, `LCD`=0x00, `in_ready`=0, `init_done`=0, state=POWERUP, init index=0.
- POWERUP: count `T_POWERUP` cycles, then go to INIT_LOAD.
- INIT_LOAD: latch init ROM entry [index] with `RS`=0, then go to SETUP.
  - Init ROM, in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- SETUP (`T_SETUP` cycles) → PULSE (`en`=1, `T_PULSE` cycles) → HOLD (`en`=0, `T_HOLD` cycles) → WAIT.
- WAIT uses `T_EXEC_LONG` when the latched byte has RS=0 and data ∈ {0x01, 0x02, 0x03}; otherwise `T_EXEC`.
- WAIT exit:
  - init index < 5: increment index, go to INIT_LOAD.
  - init index = 5: set `init_done`, go to IDLE.
  - otherwise (normal operation): go to IDLE.
- IDLE: `in_ready`=1. Handshake completes on a cycle where `in_valid && in_ready`.
  - On that edge, latch `in_rs`/`in_data` into `RS`/`LCD` and go to SETUP.
- `in_ready` is registered and high only in IDLE. `in_valid` outside IDLE is ignored and never latched.
- `RS`/`LCD` change only on a latch edge. They hold their value through IDLE, i.e. the last written byte stays on the bus.
- Delay counter: loaded with N−1 on state entry, state exits when it reaches 0. Width is `$clog2` of the largest parameter. Every parameter is ≥ 1.

## Timing
- Handshake completes at edge E. From there:
  - `RS`/`LCD` are valid from E+1.
  - `en` rises at E+1+`T_SETUP` and falls at E+1+`T_SETUP`+`T_PULSE`.
  - `in_ready` reasserts at E+1+`T_SETUP`+`T_PULSE`+`T_HOLD`+`T_exec`.
- Maximum throughput: one byte per (1+`T_SETUP`+`T_PULSE`+`T_HOLD`+`T_exec`) cycles.
- First init `en` rise: `T_POWERUP`+1+`T_SETUP` cycles after reset release.
- `rstBt` asserted in any state, including mid-pulse: at the next edge all outputs return to their reset values (`en` drops immediately) and the init sequence restarts from POWERUP.
- `in_valid` held high continuously: consecutive bytes are accepted back-to-back with no lost or duplicated byte.
- `en` never glitches. It comes from the registered state only.

## Structure
- `lcd_pkg` holds:
  - the state enum;
  - the init ROM contents and length (6);
  - command constants `LCD_CLEAR`=0x01, `LCD_HOME`=0x02, `LCD_FUNC_8B2L`=0x38, `LCD_DISP_ON`=0x0C, `LCD_ENTRY_INC`=0x06;
  - a function `is_long_cmd(rs, data)`.
- One sub-module, `lcd_delay_counter`: loadable down-counter with `load`, `value`, and `done` outputs.
- FSM and output registers live in `lcd_bus_if`.

## Test plan
Bench parameters: `T_POWERUP`=20, `T_SETUP`=2, `T_PULSE`=3, `T_HOLD`=1, `T_EXEC`=5, `T_EXEC_LONG`=12.
- Release reset, idle upstream → exactly 6 `en` pulses with `LCD` = 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and `RS`=0. The gap after the 0x01 pulse is 12 wait cycles. `init_done` and `in_ready` rise together.
- After init, send `in_rs`=1, `in_data`=0x41 → `RS`=1, `LCD`=0x41 one cycle after the handshake. `en` is high for exactly 3 cycles starting 2 cycles later. `in_ready` returns 12 cycles after the handshake edge.
- Send commands 0x01 then 0x80 → WAIT lasts 12 cycles for 0x01 and 5 cycles for 0x80.
- Hold `in_valid` high with 4 distinct bytes → exactly 4 pulses in order. `in_valid` asserted during busy states is ignored.
- Assert `rstBt` during PULSE of the 3rd init byte → `en`=0 next cycle, `init_done`=0, and the init sequence restarts from 0x38 after 20 cycles.
- `RW` is checked 0 every cycle throughout all scenarios.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-class 8-bit bus engine:
// state encoding, init ROM, command bytes and the long-execution predicate.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_POWERUP   = 4'd0,
        ST_INIT_LOAD = 4'd1,
        ST_SETUP     = 4'd2,
        ST_PULSE     = 4'd3,
        ST_HOLD      = 4'd4,
        ST_WAIT      = 4'd5,
        ST_IDLE      = 4'd6
    } lcd_state_e;

    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME      = 8'h02;
    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

    localparam int         INIT_LEN  = 6;
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

    // Function set is written three times, as the controller's reset-by-instruction requires.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return LCD_FUNC_8B2L;
            3'd3:             return LCD_DISP_ON;
            3'd4:             return LCD_CLEAR;
            3'd5:             return LCD_ENTRY_INC;
            default:          return 8'h00;
        endcase
    endfunction

    // Clear and return-home (0x02, and its 0x03 alias) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CLEAR || data == LCD_HOME || data == 8'h03);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter: 'load' captures 'value', then it counts down and
// holds at zero; 'done' is high while the count is zero.
module lcd_delay_counter #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_if.sv
// HD44780-class 8-bit write-only bus engine: runs the power-up init sequence,
// then writes one upstream byte at a time with setup/pulse/hold/exec timing.
module lcd_bus_if
    import lcd_pkg::*;
#(
    parameter int T_POWERUP   = 4_000_000,
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 50,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 4000,
    parameter int T_EXEC_LONG = 164_000
) (
    input  logic       clk,
    input  logic       rstBt,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic [7:0] LCD,
    output logic       RS,
    output logic       RW,
    output logic       en,
    output logic [3:0] dbg_state
);

    // Handshake: a byte transfers on any rising edge where in_valid && in_ready;
    // in_ready is registered, high only in IDLE, and in_valid is ignored elsewhere.

    localparam int MAX_T = max_int(max_int(max_int(T_POWERUP, T_SETUP), max_int(T_PULSE, T_HOLD)),
                                   max_int(T_EXEC, T_EXEC_LONG));
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CW-1:0] C_POWERUP   = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] C_SETUP     = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_PULSE     = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] C_HOLD      = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_EXEC      = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] C_EXEC_LONG = CW'(T_EXEC_LONG - 1);

    lcd_state_e    state, next_state;
    logic [2:0]    init_idx;
    logic          cnt_load;
    logic [CW-1:0] cnt_value;
    logic          cnt_done;
    logic          accept;

    assign accept    = (state == ST_IDLE) && in_valid && in_ready;
    assign RW        = 1'b0;
    assign dbg_state = state;

    // Reset preloads the POWERUP count, so POWERUP needs no entry load.
    lcd_delay_counter #(
        .W       (CW),
        .RST_VAL (C_POWERUP)
    ) u_delay (
        .clk   (clk),
        .rst   (rstBt),
        .load  (cnt_load),
        .value (cnt_value),
        .done  (cnt_done)
    );

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        case (state)
            ST_POWERUP: begin
                if (cnt_done) next_state = ST_INIT_LOAD;
            end
            ST_INIT_LOAD: begin
                next_state = ST_SETUP;
                cnt_load   = 1'b1;
                cnt_value  = C_SETUP;
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    next_state = ST_PULSE;
                    cnt_load   = 1'b1;
                    cnt_value  = C_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_done) begin
                    next_state = ST_HOLD;
                    cnt_load   = 1'b1;
                    cnt_value  = C_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    next_state = ST_WAIT;
                    cnt_load   = 1'b1;
                    cnt_value  = is_long_cmd(RS, LCD) ? C_EXEC_LONG : C_EXEC;
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    next_state = (!init_done && init_idx < INIT_LAST) ? ST_INIT_LOAD : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SETUP;
                    cnt_load   = 1'b1;
                    cnt_value  = C_SETUP;
                end
            end
            default: next_state = ST_POWERUP;
        endcase
    end

    // en and in_ready are decoded from next_state so both are clean register outputs.
    always_ff @(posedge clk) begin
        if (rstBt) begin
            state     <= ST_POWERUP;
            en        <= 1'b0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
            init_idx  <= 3'd0;
            RS        <= 1'b0;
            LCD       <= 8'h00;
        end else begin
            state    <= next_state;
            en       <= (next_state == ST_PULSE);
            in_ready <= (next_state == ST_IDLE);
            if (state == ST_INIT_LOAD) begin
                RS  <= 1'b0;
                LCD <= init_rom(init_idx);
            end
            if (accept) begin
                RS  <= in_rs;
                LCD <= in_data;
            end
            if (state == ST_WAIT && cnt_done && !init_done) begin
                if (init_idx < INIT_LAST) init_idx  <= init_idx + 3'd1;
                else                      init_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_if.sv
// Directed bench for lcd_bus_if with short timing parameters: init sequence,
// single write timing, exec wait lengths, back-to-back writes and mid-pulse reset.
module tb_lcd_bus_if;

    localparam int T_POWERUP   = 20;
    localparam int T_SETUP     = 2;
    localparam int T_PULSE     = 3;
    localparam int T_HOLD      = 1;
    localparam int T_EXEC      = 5;
    localparam int T_EXEC_LONG = 12;
    // Cycles from reset release to first en-high sample: T_POWERUP + 1 + T_SETUP.
    localparam int FIRST_RISE  = 23;
    // One byte per 1 + T_SETUP + T_PULSE + T_HOLD + T_EXEC cycles.
    localparam int BYTE_PERIOD = 12;

    localparam logic [7:0] INIT_BYTES [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    localparam int         INIT_WAITS [6] = '{5, 5, 5, 5, 12, 5};
    localparam logic [7:0] B2B_BYTES  [4] = '{8'h48, 8'h65, 8'h6C, 8'h21};

    logic       clk = 1'b0;
    logic       rstBt = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       init_done;
    logic [7:0] LCD;
    logic       RS;
    logic       RW;
    logic       en;
    logic [3:0] dbg_state;

    int tot = 0;
    int bad = 0;

    logic [8:0] exp_q[$];
    logic [8:0] pulse_q[$];
    int         plen_q[$];
    int         wait_q[$];

    lcd_bus_if #(
        .T_POWERUP   (T_POWERUP),
        .T_SETUP     (T_SETUP),
        .T_PULSE     (T_PULSE),
        .T_HOLD      (T_HOLD),
        .T_EXEC      (T_EXEC),
        .T_EXEC_LONG (T_EXEC_LONG)
    ) dut (
        .clk       (clk),
        .rstBt     (rstBt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs     (in_rs),
        .in_data   (in_data),
        .init_done (init_done),
        .LCD       (LCD),
        .RS        (RS),
        .RW        (RW),
        .en        (en),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", tot, bad);
        $fatal(1, "watchdog");
    end

    // Bus monitor, sampled 1 time unit after each rising edge.
    logic       prev_en = 1'b0;
    logic [8:0] pulse_val = '0;
    int         plen = 0;
    int         wrun = 0;

    always @(posedge clk) begin
        #1;
        tot++;
        if (RW !== 1'b0) begin
            bad++;
            $display("FAIL rw_low: RW=%b expected 0", RW);
        end
        if (rstBt) begin
            prev_en = 1'b0;
            plen    = 0;
            wrun    = 0;
        end else begin
            if (en) begin
                if (!prev_en) begin
                    pulse_q.push_back({RS, LCD});
                    pulse_val = {RS, LCD};
                    plen      = 0;
                end else begin
                    tot++;
                    if ({RS, LCD} !== pulse_val) begin
                        bad++;
                        $display("FAIL bus_stable: {RS,LCD}=%h expected %h while en high", {RS, LCD}, pulse_val);
                    end
                end
                plen++;
            end else if (prev_en) begin
                plen_q.push_back(plen);
            end
            prev_en = en;
            if (dbg_state == 4'd5) begin
                wrun++;
            end else if (wrun > 0) begin
                wait_q.push_back(wrun);
                wrun = 0;
            end
        end
    end

    task automatic clear_logs();
        exp_q.delete();
        pulse_q.delete();
        plen_q.delete();
        wait_q.delete();
    endtask

    task automatic check_pulses(input string name);
        logic [8:0] exp_v;
        logic [8:0] got_v;
        tot++;
        if (pulse_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s_count: pulses=%0d expected %0d", name, pulse_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = (pulse_q.size() > 0) ? pulse_q.pop_front() : 9'bx;
            tot++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL %s_byte: {RS,LCD}=%h expected %h", name, got_v, exp_v);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 200 && !in_ready; n++) @(negedge clk);
        tot++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle_timeout: in_ready=%b expected 1", name, in_ready);
        end
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] d);
        wait_idle("send");
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstBt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tot++; if (en !== 1'b0)          begin bad++; $display("FAIL reset_en: en=%b expected 0", en); end
        tot++; if (RS !== 1'b0)          begin bad++; $display("FAIL reset_rs: RS=%b expected 0", RS); end
        tot++; if (LCD !== 8'h00)        begin bad++; $display("FAIL reset_lcd: LCD=%h expected 00", LCD); end
        tot++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL reset_ready: in_ready=%b expected 0", in_ready); end
        tot++; if (init_done !== 1'b0)   begin bad++; $display("FAIL reset_init_done: init_done=%b expected 0", init_done); end
        tot++; if (dbg_state !== 4'd0)   begin bad++; $display("FAIL reset_state: dbg_state=%0d expected 0", dbg_state); end
    endtask

    task automatic test_init();
        int first_rise;
        first_rise = 0;
        clear_logs();
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, INIT_BYTES[i]});
        rstBt = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (en && first_rise == 0) first_rise = n;
            tot++;
            if (in_ready !== init_done) begin
                bad++;
                $display("FAIL init_ready_done: in_ready=%b expected init_done=%b at cycle %0d", in_ready, init_done, n);
            end
            if (init_done) break;
        end
        tot++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL init_timeout: init_done=%b expected 1", init_done);
        end
        @(negedge clk);
        tot++;
        if (first_rise != FIRST_RISE) begin
            bad++;
            $display("FAIL init_first_rise: cycle=%0d expected %0d", first_rise, FIRST_RISE);
        end
        check_pulses("init");
        tot++;
        if (wait_q.size() != 6) begin
            bad++;
            $display("FAIL init_wait_count: waits=%0d expected 6", wait_q.size());
        end
        for (int i = 0; i < 6 && i < wait_q.size(); i++) begin
            tot++;
            if (wait_q[i] != INIT_WAITS[i]) begin
                bad++;
                $display("FAIL init_wait_len: wait[%0d]=%0d expected %0d", i, wait_q[i], INIT_WAITS[i]);
            end
        end
        for (int i = 0; i < plen_q.size(); i++) begin
            tot++;
            if (plen_q[i] != T_PULSE) begin
                bad++;
                $display("FAIL init_pulse_len: pulse[%0d]=%0d expected %0d", i, plen_q[i], T_PULSE);
            end
        end
        tot++;
        if (dbg_state !== 4'd6) begin
            bad++;
            $display("FAIL init_idle_state: dbg_state=%0d expected 6", dbg_state);
        end
    endtask

    task automatic test_char();
        clear_logs();
        wait_idle("char");
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h41;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_rs    = 1'b0;
        in_data  = 8'h00;
        tot++; if (RS !== 1'b1)   begin bad++; $display("FAIL char_rs: RS=%b expected 1", RS); end
        tot++; if (LCD !== 8'h41) begin bad++; $display("FAIL char_lcd: LCD=%h expected 41", LCD); end
        // k counts rising edges after the handshake edge.
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            tot++;
            if (en !== (k >= 2 && k <= 4)) begin
                bad++;
                $display("FAIL char_en: en=%b expected %b at k=%0d", en, (k >= 2 && k <= 4), k);
            end
            tot++;
            if (in_ready !== (k >= 11)) begin
                bad++;
                $display("FAIL char_ready: in_ready=%b expected %b at k=%0d", in_ready, (k >= 11), k);
            end
        end
        tot++;
        if ({RS, LCD} !== 9'h141) begin
            bad++;
            $display("FAIL char_bus_hold: {RS,LCD}=%h expected 141", {RS, LCD});
        end
        tot++;
        if (wait_q.size() != 1 || wait_q[0] != T_EXEC) begin
            bad++;
            $display("FAIL char_wait: waits=%0d first=%0d expected one of %0d", wait_q.size(),
                     (wait_q.size() > 0) ? wait_q[0] : -1, T_EXEC);
        end
    endtask

    task automatic test_wait_len();
        clear_logs();
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h80});
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h80);
        wait_idle("wait_len");
        @(negedge clk);
        check_pulses("wait_len");
        tot++;
        if (wait_q.size() != 2) begin
            bad++;
            $display("FAIL wait_len_count: waits=%0d expected 2", wait_q.size());
        end
        tot++;
        if (wait_q.size() < 1 || wait_q[0] != T_EXEC_LONG) begin
            bad++;
            $display("FAIL wait_len_clear: wait=%0d expected %0d", (wait_q.size() > 0) ? wait_q[0] : -1, T_EXEC_LONG);
        end
        tot++;
        if (wait_q.size() < 2 || wait_q[1] != T_EXEC) begin
            bad++;
            $display("FAIL wait_len_ddram: wait=%0d expected %0d", (wait_q.size() > 1) ? wait_q[1] : -1, T_EXEC);
        end
    endtask

    task automatic test_back_to_back();
        int    i;
        int    hs_cyc[$];
        logic  will;
        clear_logs();
        for (int j = 0; j < 4; j++) exp_q.push_back({1'b1, B2B_BYTES[j]});
        wait_idle("b2b");
        i        = 0;
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = B2B_BYTES[0];
        for (int c = 0; c < 300 && i < 4; c++) begin
            will = in_ready;
            @(negedge clk);
            if (will) begin
                hs_cyc.push_back(c);
                i++;
                if (i < 4) in_data = B2B_BYTES[i];
                else       in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tot++;
        if (i != 4) begin
            bad++;
            $display("FAIL b2b_handshakes: count=%0d expected 4", i);
        end
        wait_idle("b2b");
        @(negedge clk);
        check_pulses("b2b");
        for (int j = 1; j < hs_cyc.size(); j++) begin
            tot++;
            if (hs_cyc[j] - hs_cyc[j-1] != BYTE_PERIOD) begin
                bad++;
                $display("FAIL b2b_period: gap=%0d expected %0d", hs_cyc[j] - hs_cyc[j-1], BYTE_PERIOD);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int   rises;
        int   first_rise;
        logic pe;
        rstBt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstBt = 1'b0;
        rises = 0;
        pe    = 1'b0;
        for (int n = 0; n < 300 && rises < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (en && !pe) rises++;
            pe = en;
        end
        tot++;
        if (rises != 3 || dbg_state !== 4'd3) begin
            bad++;
            $display("FAIL rst_mid_reach: rises=%0d state=%0d expected 3 and 3", rises, dbg_state);
        end
        rstBt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tot++; if (en !== 1'b0)        begin bad++; $display("FAIL rst_mid_en: en=%b expected 0", en); end
        tot++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: init_done=%b expected 0", init_done); end
        tot++; if (LCD !== 8'h00)      begin bad++; $display("FAIL rst_mid_lcd: LCD=%h expected 00", LCD); end
        tot++; if (dbg_state !== 4'd0) begin bad++; $display("FAIL rst_mid_state: dbg_state=%0d expected 0", dbg_state); end
        rstBt = 1'b0;
        clear_logs();
        for (int j = 0; j < 6; j++) exp_q.push_back({1'b0, INIT_BYTES[j]});
        first_rise = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (en) begin
                first_rise = n;
                break;
            end
        end
        tot++;
        if (first_rise != FIRST_RISE) begin
            bad++;
            $display("FAIL rst_mid_restart: first rise cycle=%0d expected %0d", first_rise, FIRST_RISE);
        end
        tot++;
        if ({RS, LCD} !== 9'h038) begin
            bad++;
            $display("FAIL rst_mid_first_byte: {RS,LCD}=%h expected 038", {RS, LCD});
        end
        for (int n = 0; n < 300 && !init_done; n++) @(negedge clk);
        tot++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_init_timeout: init_done=%b expected 1", init_done);
        end
        @(negedge clk);
        check_pulses("rst_mid");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_init();
        test_char();
        test_wait_len();
        test_back_to_back();
        test_reset_mid_pulse();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
